// File: rtl/uart_apb_cmd_pkg.sv
// Shared definitions for the UART byte-command APB initiator:
// command opcodes, default response bytes, FSM state encoding.
package uart_apb_cmd_pkg;

    localparam logic [7:0] OP_WRITE     = 8'h57;  // 'W'
    localparam logic [7:0] OP_READ      = 8'h52;  // 'R'
    localparam logic [7:0] DEF_ACK_BYTE = 8'h4B;  // 'K'
    localparam logic [7:0] DEF_ERR_BYTE = 8'h45;  // 'E'

    // Width of the ACCESS wait-state counter; covers TIMEOUT up to 255
    localparam int TMR_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    // True for the two opcodes that start an APB transfer
    function automatic logic is_known_op(input logic [7:0] b);
        return (b == OP_WRITE) || (b == OP_READ);
    endfunction

endpackage

// File: rtl/apb_access_timer.sv
// Wait-state counter for the APB ACCESS phase. Cleared on the way into
// ACCESS, counts cycles where the slave holds PREADY low, and flags the
// cycle in which the wait would reach TIMEOUT. TIMEOUT of 0 never expires.
module apb_access_timer
    import uart_apb_cmd_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic PCLK,
    input  logic PRESET,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TMR_WIDTH-1:0] count_reg;

    // Count waiting ACCESS cycles; restart from zero for each transfer
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // Expiry fires in the TIMEOUT-th waiting cycle, so ACCESS lasts exactly
    // TIMEOUT cycles when PREADY never rises
    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign expired = 1'b0;
        end else begin : g_timeout
            localparam logic [TMR_WIDTH-1:0] LAST_WAIT = TMR_WIDTH'(TIMEOUT - 1);
            assign expired = en && (count_reg == LAST_WAIT);
        end
    endgenerate

endmodule

// File: rtl/uart_apb_cmd_master.sv
// Byte-command APB initiator: collects 'W' addr data / 'R' addr commands
// from a UART receive strobe, runs one APB transfer, and hands back one
// response byte (ACK, read data or ERR) on a valid/ready transmit port.
module uart_apb_cmd_master
    import uart_apb_cmd_pkg::*;
#(
    parameter int         ADDR_WIDTH = 5,
    parameter int         TIMEOUT    = 255,
    parameter logic [7:0] ACK_BYTE   = DEF_ACK_BYTE,
    parameter logic [7:0] ERR_BYTE   = DEF_ERR_BYTE
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic [7:0]            RX_DATA,
    input  logic                  RX_VALID,
    output logic [7:0]            TX_DATA,
    output logic                  TX_VALID,
    input  logic                  TX_READY,
    output logic                  BUSY,
    output logic                  DROPPED,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [7:0]            PWDATA,
    input  logic [7:0]            PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    state_t                  state_reg;
    state_t                  state_next;
    logic                    write_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [7:0]              wdata_reg;
    logic [7:0]              resp_reg;
    logic                    dropped_reg;
    logic                    tmr_clr;
    logic                    tmr_en;
    logic                    tmr_expired;

    apb_access_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    // State register; reset aborts any transfer in flight
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state: byte collection, fixed one-cycle SETUP, ACCESS until
    // PREADY or timeout, then hold the response until it is taken
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (RX_VALID) state_next = is_known_op(RX_DATA) ? GET_ADDR : RESP;
            GET_ADDR: if (RX_VALID) state_next = write_reg ? GET_DATA : SETUP;
            GET_DATA: if (RX_VALID) state_next = SETUP;
            SETUP:    state_next = ACCESS;
            ACCESS:   if (PREADY || tmr_expired) state_next = RESP;
            RESP:     if (TX_READY) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Outputs decoded from state so reset clears them without a clock
    always_comb begin
        PSEL     = (state_reg == SETUP) || (state_reg == ACCESS);
        PENABLE  = (state_reg == ACCESS);
        TX_VALID = (state_reg == RESP);
        BUSY     = (state_reg == SETUP) || (state_reg == ACCESS) || (state_reg == RESP);
        tmr_clr  = (state_reg == SETUP);
        tmr_en   = (state_reg == ACCESS) && !PREADY;
    end

    // Command fields and response byte; fields stay put from SETUP
    // through ACCESS because they only load while collecting bytes
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            write_reg   <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            resp_reg    <= '0;
            dropped_reg <= 1'b0;
        end else begin
            if (RX_VALID && BUSY) begin
                dropped_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (RX_VALID) begin
                        write_reg <= (RX_DATA == OP_WRITE);
                        if (!is_known_op(RX_DATA)) begin
                            resp_reg <= ERR_BYTE;
                        end
                    end
                end
                GET_ADDR: if (RX_VALID) addr_reg  <= RX_DATA[ADDR_WIDTH-1:0];
                GET_DATA: if (RX_VALID) wdata_reg <= RX_DATA;
                ACCESS: begin
                    if (PREADY) begin
                        if (PSLVERR)        resp_reg <= ERR_BYTE;
                        else if (write_reg) resp_reg <= ACK_BYTE;
                        else                resp_reg <= PRDATA;
                    end else if (tmr_expired) begin
                        resp_reg <= ERR_BYTE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign PADDR   = addr_reg;
    assign PWRITE  = write_reg;
    assign PWDATA  = wdata_reg;
    assign TX_DATA = resp_reg;
    assign DROPPED = dropped_reg;

endmodule

// File: tb/tb_uart_apb_cmd_master.sv
// Directed bench for uart_apb_cmd_master with TIMEOUT=8. Inputs change and
// outputs are sampled on the falling edge of PCLK.
module tb_uart_apb_cmd_master;

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       TX_READY;
    logic       BUSY;
    logic       DROPPED;
    logic [4:0] PADDR;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic       PSLVERR;

    int pass_cnt  = 0;
    int total_cnt = 0;

    uart_apb_cmd_master #(
        .ADDR_WIDTH (5),
        .TIMEOUT    (8),
        .ACK_BYTE   (8'h4B),
        .ERR_BYTE   (8'h45)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .RX_DATA  (RX_DATA),
        .RX_VALID (RX_VALID),
        .TX_DATA  (TX_DATA),
        .TX_VALID (TX_VALID),
        .TX_READY (TX_READY),
        .BUSY     (BUSY),
        .DROPPED  (DROPPED),
        .PADDR    (PADDR),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    // One receive strobe; called and returns on a falling edge
    task automatic rx(input logic [7:0] b);
        RX_VALID = 1'b1;
        RX_DATA  = b;
        @(negedge PCLK);
        RX_VALID = 1'b0;
        RX_DATA  = 8'h00;
    endtask

    // Slave model: ready in the ready_on-th ACCESS cycle (0 = never).
    // Returns once TX_VALID is seen or a 40-cycle budget runs out.
    task automatic run_apb(input int ready_on, input logic err, input logic [7:0] rdata,
                           output int pen_cnt, output logic psel_seen, output logic done);
        pen_cnt   = 0;
        psel_seen = 1'b0;
        done      = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (TX_VALID) begin
                done = 1'b1;
                break;
            end
            if (PSEL) psel_seen = 1'b1;
            if (PENABLE) pen_cnt++;
            if (PENABLE && pen_cnt == ready_on) begin
                PREADY  = 1'b1;
                PSLVERR = err;
                PRDATA  = rdata;
            end else begin
                PREADY  = 1'b0;
                PSLVERR = 1'b0;
                PRDATA  = 8'h00;
            end
            @(negedge PCLK);
        end
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
    endtask

    // Take the pending response and confirm the FSM went back to IDLE
    task automatic accept(input string tag);
        TX_READY = 1'b1;
        @(negedge PCLK);
        TX_READY = 1'b0;
        chk({tag, "_txv_after"}, TX_VALID, 0);
        chk({tag, "_busy_after"}, BUSY, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   pen;
        logic psel_seen;
        logic done;
        int   seen;

        PRESET   = 1'b1;
        RX_DATA  = 8'h00;
        RX_VALID = 1'b0;
        TX_READY = 1'b0;
        PRDATA   = 8'h00;
        PREADY   = 1'b0;
        PSLVERR  = 1'b0;
        repeat (2) @(negedge PCLK);

        // Reset state
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_txv", TX_VALID, 0);
        chk("rst_txdata", TX_DATA, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_dropped", DROPPED, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwrite", PWRITE, 0);
        PRESET = 1'b0;
        @(negedge PCLK);

        // Write 57,03,A5 with zero wait states
        rx(8'h57); rx(8'h03); rx(8'hA5);
        chk("wr_setup_psel", PSEL, 1);
        chk("wr_setup_penable", PENABLE, 0);
        chk("wr_setup_paddr", PADDR, 5'h03);
        chk("wr_setup_pwrite", PWRITE, 1);
        chk("wr_setup_pwdata", PWDATA, 8'hA5);
        chk("wr_setup_busy", BUSY, 1);
        run_apb(1, 1'b0, 8'h00, pen, psel_seen, done);
        chk("wr_done", done, 1);
        chk("wr_access_cycles", pen, 1);
        chk("wr_txdata", TX_DATA, 8'h4B);
        chk("wr_psel_dropped", PSEL, 0);
        repeat (3) @(negedge PCLK);
        chk("wr_txv_held", TX_VALID, 1);
        chk("wr_txdata_held", TX_DATA, 8'h4B);
        accept("wr");

        // Read 52,1F with four wait states
        rx(8'h52); rx(8'h1F);
        chk("rd_setup_paddr", PADDR, 5'h1F);
        chk("rd_setup_pwrite", PWRITE, 0);
        run_apb(5, 1'b0, 8'h3C, pen, psel_seen, done);
        chk("rd_done", done, 1);
        chk("rd_penable_cycles", pen, 5);
        chk("rd_txdata", TX_DATA, 8'h3C);
        accept("rd");

        // Slave error
        rx(8'h52); rx(8'h04);
        run_apb(1, 1'b1, 8'h77, pen, psel_seen, done);
        chk("slverr_done", done, 1);
        chk("slverr_txdata", TX_DATA, 8'h45);
        accept("slverr");

        // Bad opcode: error response without any APB cycle
        rx(8'h41);
        run_apb(1, 1'b0, 8'h00, pen, psel_seen, done);
        chk("badop_done", done, 1);
        chk("badop_psel_seen", psel_seen, 0);
        chk("badop_txdata", TX_DATA, 8'h45);
        accept("badop");

        // Timeout: PREADY never rises
        rx(8'h52); rx(8'h02);
        run_apb(0, 1'b0, 8'h00, pen, psel_seen, done);
        chk("tmo_done", done, 1);
        chk("tmo_access_cycles", pen, 8);
        chk("tmo_psel", PSEL, 0);
        chk("tmo_penable", PENABLE, 0);
        chk("tmo_txdata", TX_DATA, 8'h45);
        accept("tmo");

        // Next read after a timeout completes normally
        rx(8'h52); rx(8'h06);
        run_apb(1, 1'b0, 8'h5A, pen, psel_seen, done);
        chk("post_tmo_done", done, 1);
        chk("post_tmo_txdata", TX_DATA, 8'h5A);
        accept("post_tmo");

        // Backpressure with a byte arriving during RESP
        chk("pre_drop_dropped", DROPPED, 0);
        rx(8'h52); rx(8'h07);
        run_apb(1, 1'b0, 8'h99, pen, psel_seen, done);
        chk("bp_done", done, 1);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) rx(8'h52);
            else @(negedge PCLK);
        end
        chk("bp_dropped", DROPPED, 1);
        chk("bp_txv", TX_VALID, 1);
        chk("bp_busy", BUSY, 1);
        chk("bp_txdata", TX_DATA, 8'h99);
        accept("bp");

        // Back in IDLE: a fresh write decodes from its first byte
        rx(8'h57); rx(8'h0A); rx(8'hC3);
        chk("post_bp_paddr", PADDR, 5'h0A);
        chk("post_bp_pwrite", PWRITE, 1);
        chk("post_bp_pwdata", PWDATA, 8'hC3);
        run_apb(1, 1'b0, 8'h00, pen, psel_seen, done);
        chk("post_bp_txdata", TX_DATA, 8'h4B);

        // Byte and TX_READY in the same RESP cycle: byte is discarded
        RX_VALID = 1'b1;
        RX_DATA  = 8'h41;
        TX_READY = 1'b1;
        @(negedge PCLK);
        RX_VALID = 1'b0;
        TX_READY = 1'b0;
        @(negedge PCLK);
        chk("same_cycle_txv", TX_VALID, 0);
        chk("same_cycle_busy", BUSY, 0);

        // Reset in the middle of ACCESS
        rx(8'h57); rx(8'h01); rx(8'h22);
        PREADY = 1'b0;
        @(negedge PCLK);
        chk("rst_mid_penable_before", PENABLE, 1);
        #2 PRESET = 1'b1;
        #1;
        chk("rst_mid_psel", PSEL, 0);
        chk("rst_mid_penable", PENABLE, 0);
        chk("rst_mid_txv", TX_VALID, 0);
        chk("rst_mid_dropped", DROPPED, 0);
        @(negedge PCLK);
        PRESET = 1'b0;
        PREADY = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge PCLK);
            if (TX_VALID || PSEL) seen++;
        end
        PREADY = 1'b0;
        chk("rst_mid_no_resp", seen, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
